// File: rtl/fractal_pkg.sv
// Shared types and constants for the fractal renderer's framebuffer write path.
package fractal_pkg;

    typedef logic [15:0] pixel_t;
    typedef logic [31:0] fb_addr_t;

    localparam int unsigned FB_WORDS_DEFAULT = 307200;

    typedef struct packed {
        pixel_t   data;
        fb_addr_t addr;
    } pix_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_e;

    // Framebuffer words are 16 bits, so the byte address is twice the word index.
    function automatic fb_addr_t fb_byte_addr(input fb_addr_t base, input fb_addr_t word);
        return base + (word << 1);
    endfunction

endpackage

// File: rtl/pixel_write_buffer_if.sv
// Pixel request bus from the write arbitrator and the Avalon-MM write master bus.
interface pix_req_if;
    import fractal_pkg::*;

    pixel_t   in_data;
    fb_addr_t in_addr;
    logic     in_write_en;
    logic     in_ack;

    modport master (output in_data, output in_addr, output in_write_en, input in_ack);
    modport slave  (input in_data, input in_addr, input in_write_en, output in_ack);
endinterface

interface avm_wr_if;
    import fractal_pkg::*;

    fb_addr_t    avm_address;
    pixel_t      avm_writedata;
    logic [1:0]  avm_byteenable;
    logic        avm_write;
    logic        avm_waitrequest;

    modport master (output avm_address, output avm_writedata, output avm_byteenable,
                    output avm_write, input avm_waitrequest);
    modport slave  (input avm_address, input avm_writedata, input avm_byteenable,
                    input avm_write, output avm_waitrequest);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO exposing the head entry and the one behind it for back-to-back reads.
module sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [WIDTH-1:0]           next_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = rd_ptr_q + AW'(1);

    assign head_data = mem[rd_ptr_q];
    assign next_data = mem[rd_nxt];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_nxt;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pixel_write_buffer.sv
// Buffers pixel writes from the arbitrator and replays them in order as Avalon-MM writes.
module pixel_write_buffer
    import fractal_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FB_WORDS  = FB_WORDS_DEFAULT,
    parameter fb_addr_t    BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    pix_req_if.slave    pix,
    avm_wr_if.master    avm,
    output logic [15:0] drop_count,
    output logic        empty
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic        ack_q, ack_d;
    logic        stage_vld_q, stage_vld_d;
    pix_entry_t  stage_q, stage_d;
    logic [15:0] drop_q, drop_d;
    wr_state_e   state_q, state_d;
    fb_addr_t    addr_q, addr_d;
    pixel_t      wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        write_q, write_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    pix_entry_t    head_entry;
    pix_entry_t    next_entry;
    logic          in_range;
    logic          accept;
    logic          wr_done;
    logic          load_en;
    pix_entry_t    load_entry;

    // Accepted requests sit one cycle in the stage register before entering the FIFO.
    sync_fifo #(
        .WIDTH ($bits(pix_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset),
        .push      (stage_vld_q),
        .push_data (stage_q),
        .pop       (wr_done),
        .head_data (head_entry),
        .next_data (next_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_range = (pix.in_addr < fb_addr_t'(FB_WORDS));
    assign accept   = pix.in_write_en && !ack_q && (!in_range || !fifo_full);
    assign wr_done  = write_q && !avm.avm_waitrequest;

    always_comb begin
        ack_d       = accept;
        stage_vld_d = accept && in_range;
        stage_d     = stage_q;
        drop_d      = drop_q;
        if (accept) begin
            stage_d.data = pix.in_data;
            stage_d.addr = pix.in_addr;
        end
        if (accept && !in_range && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        write_d    = write_q;
        load_en    = 1'b0;
        load_entry = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load_en    = 1'b1;
                    load_entry = head_entry;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The head pops this edge; with one entry left the follower may still be staged.
                if (wr_done) begin
                    if (fifo_count > CW'(1)) begin
                        load_en    = 1'b1;
                        load_entry = next_entry;
                    end else if (stage_vld_q) begin
                        load_en    = 1'b1;
                        load_entry = stage_q;
                    end else begin
                        state_d = ST_IDLE;
                        write_d = 1'b0;
                        be_d    = 2'b00;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_en) begin
            addr_d  = fb_byte_addr(BASE_ADDR, load_entry.addr);
            wdata_d = load_entry.data;
            be_d    = 2'b11;
            write_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_q       <= 1'b0;
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
            drop_q      <= '0;
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 2'b00;
            write_q     <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            stage_vld_q <= stage_vld_d;
            stage_q     <= stage_d;
            drop_q      <= drop_d;
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            write_q     <= write_d;
        end
    end

    assign pix.in_ack         = ack_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_write      = write_q;
    assign drop_count         = drop_q;
    assign empty              = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Directed bench for pixel_write_buffer: single write, range drop, backpressure, burst, reset.
module tb_pixel_write_buffer;
    import fractal_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] drop_count;
    logic        empty;

    always #5 clock = ~clock;

    pix_req_if pix ();
    avm_wr_if  avm ();

    pixel_write_buffer #(
        .DEPTH     (8),
        .FB_WORDS  (307200),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pix        (pix),
        .avm        (avm),
        .drop_count (drop_count),
        .empty      (empty)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int ack_cnt = 0;
    logic [31:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_cyc_q  [$];

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (pix.in_ack) ack_cnt++;
            if (avm.avm_write && !avm.avm_waitrequest) begin
                wr_addr_q.push_back(avm.avm_address);
                wr_data_q.push_back(avm.avm_writedata);
                wr_cyc_q.push_back(cyc);
                $display("write %0d: addr=%h data=%h cycle=%0d",
                         wr_addr_q.size(), avm.avm_address, avm.avm_writedata, cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Holds the request until acked; returns at 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [15:0] d, input int budget);
        bit got = 0;
        @(posedge clock);
        #1;
        pix.in_addr     = a;
        pix.in_data     = d;
        pix.in_write_en = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (pix.in_ack) begin
                got = 1;
                break;
            end
        end
        pix.in_write_en = 1'b0;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int a0;
        pix.in_write_en     = 1'b0;
        pix.in_addr         = '0;
        pix.in_data         = '0;
        avm.avm_waitrequest = 1'b0;
        tick(3);

        check("rst_ack",   pix.in_ack, 32'd0);
        check("rst_write", avm.avm_write, 32'd0);
        check("rst_addr",  avm.avm_address, 32'd0);
        check("rst_data",  avm.avm_writedata, 32'd0);
        check("rst_be",    avm.avm_byteenable, 32'd0);
        check("rst_drop",  drop_count, 32'd0);
        check("rst_empty", empty, 32'd1);
        @(negedge clock);
        reset = 1'b1;

        // Single write and its latency
        send(32'h10, 16'h0011, 20);
        check("single_ack", pix.in_ack, 32'd1);
        tick(1);
        check("single_ack_one_cycle", pix.in_ack, 32'd0);
        check("single_lat1", avm.avm_write, 32'd0);
        tick(1);
        check("single_write", avm.avm_write, 32'd1);
        check("single_addr", avm.avm_address, 32'h20);
        check("single_data", avm.avm_writedata, 32'h0011);
        check("single_be", avm.avm_byteenable, 32'd3);
        tick(1);
        check("single_write_end", avm.avm_write, 32'd0);
        check("single_empty", empty, 32'd1);
        check("single_count", wr_addr_q.size(), 32'd1);

        // Out-of-range request is acked and dropped
        n0 = wr_addr_q.size();
        send(32'hFFFF_FFFE, 16'hBEEF, 20);
        check("oor_ack", pix.in_ack, 32'd1);
        tick(6);
        check("oor_drop", drop_count, 32'd1);
        check("oor_nowrite", wr_addr_q.size(), n0);
        check("oor_empty", empty, 32'd1);

        // Backpressure: FIFO fills at 8, rest waits
        n0 = wr_addr_q.size();
        a0 = ack_cnt;
        avm.avm_waitrequest = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(32'h100 + i, 16'hA000 + 16'(i), 200);
            end
            begin
                tick(50);
                check("bp_acks", ack_cnt - a0, 32'd8);
                check("bp_held_noack", pix.in_ack, 32'd0);
                check("bp_write", avm.avm_write, 32'd1);
                check("bp_addr_stable", avm.avm_address, 32'h200);
                check("bp_data_stable", avm.avm_writedata, 32'hA000);
                check("bp_nocomplete", wr_addr_q.size(), n0);
                avm.avm_waitrequest = 1'b0;
            end
        join
        tick(30);
        check("bp_acks_all", ack_cnt - a0, 32'd10);
        check("bp_writes", wr_addr_q.size(), n0 + 10);
        for (int i = 0; i < 10; i++) begin
            if (n0 + i < wr_addr_q.size()) begin
                check($sformatf("bp_addr%0d", i), wr_addr_q[n0+i], (32'h100 + i) << 1);
                check($sformatf("bp_data%0d", i), wr_data_q[n0+i], 32'hA000 + i);
            end
        end
        check("bp_empty", empty, 32'd1);

        // Back-to-back drain of 4 queued entries
        n0 = wr_addr_q.size();
        avm.avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h40 + i, 16'h0C00 + 16'(i), 20);
        tick(3);
        avm.avm_waitrequest = 1'b0;
        tick(8);
        check("b2b_writes", wr_addr_q.size(), n0 + 4);
        for (int i = 0; i < 4; i++) begin
            if (n0 + i < wr_addr_q.size()) begin
                check($sformatf("b2b_addr%0d", i), wr_addr_q[n0+i], (32'h40 + i) << 1);
                if (i > 0)
                    check($sformatf("b2b_gap%0d", i), wr_cyc_q[n0+i] - wr_cyc_q[n0+i-1], 32'd1);
            end
        end

        // Held request is accepted at most every other cycle
        n0 = wr_addr_q.size();
        a0 = ack_cnt;
        @(posedge clock);
        #1;
        pix.in_addr     = 32'h55;
        pix.in_data     = 16'h5555;
        pix.in_write_en = 1'b1;
        tick(4);
        pix.in_write_en = 1'b0;
        tick(8);
        check("hold_acks", ack_cnt - a0, 32'd2);
        check("hold_writes", wr_addr_q.size(), n0 + 2);
        if (n0 + 1 < wr_addr_q.size()) check("hold_addr", wr_addr_q[n0+1], 32'hAA);

        // Reset while a write is stalled with 3 more queued
        avm.avm_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h200 + i, 16'h0D00 + 16'(i), 20);
        tick(3);
        n0 = wr_addr_q.size();
        check("mid_write", avm.avm_write, 32'd1);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_write", avm.avm_write, 32'd0);
        check("mid_rst_empty", empty, 32'd1);
        check("mid_rst_drop", drop_count, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        avm.avm_waitrequest = 1'b0;
        tick(20);
        check("post_rst_nowrite", wr_addr_q.size(), n0);
        check("post_rst_write", avm.avm_write, 32'd0);
        check("post_rst_empty", empty, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
